// File: rtl/digit_scan_ctrl_if.sv
// Scan-controller port bundle: enable/data towards the sequencer, digit select,
// nibble, blanking and frame-pulse back towards the display decoder.
interface digit_scan_ctrl_if;
  logic        en;
  logic [15:0] data;
  logic [1:0]  sel;
  logic [3:0]  nib;
  logic        blank;
  logic        frame;

  modport master (output en, data, input sel, nib, blank, frame);
  modport slave  (input en, data, output sel, nib, blank, frame);
endinterface

// File: rtl/digit_scan_ctrl.sv
// 4-digit time-multiplexed scan sequencer: DWELL show cycles + GAP blank cycles per digit,
// frame-coherent data capture. Optional leading-zero blanking when DIGIT_SCAN_LZB_EN is defined.
module digit_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int GAP   = 1,
  parameter int CW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  digit_scan_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    nib_q, nib_d;
  logic          blank_q, blank_d;
  logic          frame_q, frame_d;
  logic          advance;
  logic          lzb_hit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    frame_d  = 1'b0;
    advance  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          state_d  = ST_SHOW;
          sel_d    = 2'd0;
          cnt_d    = '0;
          shadow_d = bus.data;
        end
      end
      ST_SHOW: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
          sel_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DWELL - 1)) begin
          if (GAP == 0) begin
            advance = 1'b1;
          end else begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
          sel_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(GAP - 1)) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase

    // Wrapping back to digit 0 starts a new frame: recapture data there and only there.
    if (advance) begin
      state_d = ST_SHOW;
      sel_d   = sel_q + 2'd1;
      cnt_d   = '0;
      if (sel_q == 2'd3) begin
        shadow_d = bus.data;
        frame_d  = 1'b1;
      end
    end
  end

`ifdef DIGIT_SCAN_LZB_EN
  logic [3:0] lz_vec;
  assign lz_vec[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lzb
      assign lz_vec[gi] = (shadow_d[15:4*gi] == '0);
    end
  endgenerate
  assign lzb_hit = lz_vec[sel_d];
`else
  assign lzb_hit = 1'b0;
`endif

  assign nib_d   = shadow_d[{sel_d, 2'b00} +: 4];
  assign blank_d = (state_d != ST_SHOW) || lzb_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      shadow_q <= '0;
      nib_q    <= 4'd0;
      blank_q  <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      nib_q    <= nib_d;
      blank_q  <= blank_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.nib   = nib_q;
  assign bus.blank = blank_q;
  assign bus.frame = frame_q;

endmodule
